// File: rtl/exec_unit_pkg.sv
// Shared types and constants for the execution unit: ALU opcodes, CSR access
// kinds, CSR addresses and the table describing the plain read/write CSRs.
package exec_unit_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_EQ   = 5'd10,
        ALU_NE   = 5'd11,
        ALU_LT   = 5'd12,
        ALU_GE   = 5'd13,
        ALU_LTU  = 5'd14,
        ALU_GEU  = 5'd15
    } alu_op_e;

    // csr_op[1:0] selects the access kind; csr_op[2] (immediate form) is resolved upstream
    localparam logic [1:0] CSR_OP_W = 2'b01;
    localparam logic [1:0] CSR_OP_S = 2'b10;
    localparam logic [1:0] CSR_OP_C = 2'b11;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    // Read/write CSRs: address and mask of implemented (writable) bits
    localparam int NUM_RW_CSR = 6;
    localparam logic [11:0] RW_CSR_ADDR [NUM_RW_CSR] = '{
        CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL
    };
    localparam logic [31:0] RW_CSR_MASK [NUM_RW_CSR] = '{
        32'h0000_0088, 32'hFFFF_FFFC, 32'hFFFF_FFFF,
        32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF
    };

endpackage

// File: rtl/exec_csr_file.sv
// Machine-mode CSR storage with W/S/C access and sticky access-fault flag.
// Optional 64-bit mcycle/mcycleh counter when EXEC_UNIT_MCYCLE_EN is defined.
module exec_csr_file
    import exec_unit_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter logic [31:0] HART_ID    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_en,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_fault
);

    logic [31:0]           rw_reg [NUM_RW_CSR];
    logic [NUM_RW_CSR-1:0] rw_hit;
    logic [31:0]           old_value;
    logic [31:0]           wr_value;
    logic                  addr_valid;
    logic                  read_only;
    logic                  access_ok;
    logic                  wr_en;
    logic [31:0]           csr_rdata_reg;
    logic                  csr_fault_reg;
    logic                  csr_unused;

    assign csr_unused = csr_op[2];

`ifdef EXEC_UNIT_MCYCLE_EN
    logic [63:0] mcycle_reg;
`endif

    for (genvar gi = 0; gi < NUM_RW_CSR; gi++) begin : g_rw_csr
        assign rw_hit[gi] = (csr_addr == RW_CSR_ADDR[gi]);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rw_reg[gi] <= '0;
            end else if (wr_en && rw_hit[gi]) begin
                rw_reg[gi] <= wr_value & RW_CSR_MASK[gi];
            end
        end
    end

    always_comb begin
        old_value  = '0;
        addr_valid = |rw_hit;
        read_only  = 1'b0;
        for (int i = 0; i < NUM_RW_CSR; i++) begin
            if (rw_hit[i]) old_value = rw_reg[i];
        end
        if (csr_addr == CSR_MISA) begin
            old_value  = MISA_VALUE;
            addr_valid = 1'b1;
            read_only  = 1'b1;
        end
        if (csr_addr == CSR_MHARTID) begin
            old_value  = HART_ID;
            addr_valid = 1'b1;
            read_only  = 1'b1;
        end
`ifdef EXEC_UNIT_MCYCLE_EN
        if (csr_addr == CSR_MCYCLE) begin
            old_value  = mcycle_reg[31:0];
            addr_valid = 1'b1;
        end
        if (csr_addr == CSR_MCYCLEH) begin
            old_value  = mcycle_reg[63:32];
            addr_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        wr_value = old_value;
        case (csr_op[1:0])
            CSR_OP_W: wr_value = csr_wdata;
            CSR_OP_S: wr_value = old_value | csr_wdata;
            CSR_OP_C: wr_value = old_value & ~csr_wdata;
            default:  wr_value = old_value;
        endcase
    end

    // Read-only CSRs accept S/C only as a pure read (zero operand)
    assign access_ok = (csr_op[1:0] != 2'b00) && addr_valid &&
                       !(read_only && ((csr_op[1:0] == CSR_OP_W) || (csr_wdata != '0)));
    assign wr_en     = csr_en && access_ok && !read_only;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_rdata_reg <= '0;
            csr_fault_reg <= 1'b0;
        end else if (csr_en) begin
            if (access_ok) begin
                csr_rdata_reg <= old_value;
            end else begin
                csr_rdata_reg <= '0;
                csr_fault_reg <= 1'b1;
            end
        end
    end

`ifdef EXEC_UNIT_MCYCLE_EN
    // A write to either half takes priority over that cycle's increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcycle_reg <= '0;
        end else if (wr_en && (csr_addr == CSR_MCYCLE)) begin
            mcycle_reg <= {mcycle_reg[63:32], wr_value};
        end else if (wr_en && (csr_addr == CSR_MCYCLEH)) begin
            mcycle_reg <= {wr_value, mcycle_reg[31:0]};
        end else begin
            mcycle_reg <= mcycle_reg + 64'd1;
        end
    end
`endif

    assign csr_rdata = csr_rdata_reg;
    assign csr_fault = csr_fault_reg;

endmodule

// File: rtl/exec_unit.sv
// Execution unit: registered PC adders, single-cycle ALU with branch compares,
// and the CSR file. Optional mcycle counter enabled by EXEC_UNIT_MCYCLE_EN.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter logic [31:0] HART_ID    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adder_en,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] next_pc,
    output logic [31:0] offset_pc,
    input  logic        alu_en,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_out,
    input  logic        csr_en,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        alu_fault,
    output logic        csr_fault,
    output logic        fault
);

    logic [31:0] next_pc_reg;
    logic [31:0] offset_pc_reg;
    logic [31:0] alu_out_reg;
    logic        alu_fault_reg;
    logic [31:0] alu_next;
    logic        alu_illegal;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;

    assign shamt = alu_b[4:0];
    assign lt_s  = $signed(alu_a) < $signed(alu_b);
    assign lt_u  = alu_a < alu_b;

    always_comb begin
        alu_next    = '0;
        alu_illegal = 1'b0;
        case (alu_op)
            ALU_ADD:  alu_next = alu_a + alu_b;
            ALU_SUB:  alu_next = alu_a - alu_b;
            ALU_SLL:  alu_next = alu_a << shamt;
            ALU_SLT:  alu_next = {31'b0, lt_s};
            ALU_SLTU: alu_next = {31'b0, lt_u};
            ALU_XOR:  alu_next = alu_a ^ alu_b;
            ALU_SRL:  alu_next = alu_a >> shamt;
            ALU_SRA:  alu_next = $unsigned($signed(alu_a) >>> shamt);
            ALU_OR:   alu_next = alu_a | alu_b;
            ALU_AND:  alu_next = alu_a & alu_b;
            ALU_EQ:   alu_next = {31'b0, alu_a == alu_b};
            ALU_NE:   alu_next = {31'b0, alu_a != alu_b};
            ALU_LT:   alu_next = {31'b0, lt_s};
            ALU_GE:   alu_next = {31'b0, !lt_s};
            ALU_LTU:  alu_next = {31'b0, lt_u};
            ALU_GEU:  alu_next = {31'b0, !lt_u};
            default:  alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_pc_reg   <= '0;
            offset_pc_reg <= '0;
        end else if (adder_en) begin
            next_pc_reg   <= pc + 32'd4;
            offset_pc_reg <= pc + imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_reg   <= '0;
            alu_fault_reg <= 1'b0;
        end else if (alu_en) begin
            alu_out_reg <= alu_next;
            if (alu_illegal) alu_fault_reg <= 1'b1;
        end
    end

    exec_csr_file #(
        .MISA_VALUE (MISA_VALUE),
        .HART_ID    (HART_ID)
    ) u_csr (
        .clk       (clk),
        .reset     (reset),
        .csr_en    (csr_en),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_fault (csr_fault)
    );

    assign next_pc   = next_pc_reg;
    assign offset_pc = offset_pc_reg;
    assign alu_out   = alu_out_reg;
    assign alu_fault = alu_fault_reg;
    assign fault     = alu_fault_reg | csr_fault;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; mcycle check when EXEC_UNIT_MCYCLE_EN is defined.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        adder_en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] next_pc;
    logic [31:0] offset_pc;
    logic        alu_en = 1'b0;
    logic [4:0]  alu_op = '0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [31:0] alu_out;
    logic        csr_en = 1'b0;
    logic [2:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        alu_fault;
    logic        csr_fault;
    logic        fault;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] MISA = 32'h4000_0100;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .adder_en  (adder_en),
        .pc        (pc),
        .imm       (imm),
        .next_pc   (next_pc),
        .offset_pc (offset_pc),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .csr_en    (csr_en),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .alu_fault (alu_fault),
        .csr_fault (csr_fault),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        alu_en = 1'b1; alu_op = op; alu_a = a; alu_b = b;
        step();
        alu_en = 1'b0;
        check(tag, alu_out, exp);
    endtask

    task automatic csr_acc(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata;
        step();
        csr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst next_pc", next_pc, 32'h0);
        check("rst offset_pc", offset_pc, 32'h0);
        check("rst alu_out", alu_out, 32'h0);
        check("rst csr_rdata", csr_rdata, 32'h0);
        check("rst fault", {31'b0, fault}, 32'h0);
        // Enables asserted under reset must be ignored
        adder_en = 1'b1; pc = 32'h1234; alu_en = 1'b1; alu_op = 5'd0; alu_a = 32'd7;
        step();
        check("rst hold next_pc", next_pc, 32'h0);
        check("rst hold alu_out", alu_out, 32'h0);
        adder_en = 1'b0; alu_en = 1'b0;
        reset = 1'b1;

        // PC adders
        adder_en = 1'b1; pc = 32'h1000; imm = 32'hFFFF_FFF0;
        step();
        check("next_pc 1000", next_pc, 32'h1004);
        check("offset_pc 1000", offset_pc, 32'h0FF0);
        pc = 32'hFFFF_FFFC; imm = 32'h8;
        step();
        check("next_pc wrap", next_pc, 32'h0);
        check("offset_pc wrap", offset_pc, 32'h4);
        adder_en = 1'b0; pc = 32'h5000;
        step();
        check("next_pc hold", next_pc, 32'h0);

        // ALU vectors
        alu_vec("SRA",  5'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
        alu_vec("SLTU", 5'd4,  32'd1,         32'hFFFF_FFFF, 32'd1);
        alu_vec("LT",   5'd12, 32'hFFFF_FFFF, 32'd0,         32'd1);
        alu_vec("ADD",  5'd0,  32'hFFFF_FFFF, 32'd2,         32'd1);
        alu_vec("SUB",  5'd1,  32'd3,         32'd5,         32'hFFFF_FFFE);
        alu_vec("SLL",  5'd2,  32'd1,         32'h21,        32'd2);
        alu_vec("SLT",  5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
        alu_vec("XOR",  5'd5,  32'h0000_F0F0, 32'h0000_00FF, 32'h0000_F00F);
        alu_vec("SRL",  5'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
        alu_vec("OR",   5'd8,  32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0);
        alu_vec("AND",  5'd9,  32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0);
        alu_vec("EQ",   5'd10, 32'd5,         32'd5,         32'd1);
        alu_vec("NE",   5'd11, 32'd5,         32'd5,         32'd0);
        alu_vec("GE",   5'd13, 32'hFFFF_FFFF, 32'd0,         32'd0);
        alu_vec("LTU",  5'd14, 32'hFFFF_FFFF, 32'd0,         32'd0);
        alu_vec("GEU",  5'd15, 32'd1,         32'hFFFF_FFFF, 32'd0);
        check("alu_fault clean", {31'b0, alu_fault}, 32'h0);
        alu_op = 5'd0; alu_a = 32'd9; alu_b = 32'd9;
        step();
        check("alu hold", alu_out, 32'd0);

        // CSR read/write/set/clear
        csr_acc(3'b001, 12'h340, 32'hDEAD_BEEF);
        check("csrrw mscratch old", csr_rdata, 32'h0);
        csr_acc(3'b010, 12'h340, 32'h1);
        check("csrrs mscratch old", csr_rdata, 32'hDEAD_BEEF);
        csr_acc(3'b010, 12'h340, 32'h0);
        check("mscratch after set", csr_rdata, 32'hDEAD_BEEF);
        csr_acc(3'b011, 12'h340, 32'hF);
        check("csrrc mscratch old", csr_rdata, 32'hDEAD_BEEF);
        csr_acc(3'b010, 12'h340, 32'h0);
        check("mscratch after clr", csr_rdata, 32'hDEAD_BEE0);
        csr_acc(3'b101, 12'h300, 32'hFFFF_FFFF);
        csr_acc(3'b010, 12'h300, 32'h0);
        check("mstatus mask", csr_rdata, 32'h0000_0088);
        csr_acc(3'b001, 12'h305, 32'h0000_1003);
        csr_acc(3'b010, 12'h305, 32'h0);
        check("mtvec mask", csr_rdata, 32'h0000_1000);
        csr_acc(3'b010, 12'hF14, 32'h0);
        check("mhartid", csr_rdata, 32'h0);
        csr_acc(3'b110, 12'h301, 32'h0);
        check("misa read", csr_rdata, MISA);
        check("csr_fault clean", {31'b0, csr_fault}, 32'h0);

        // ALU and CSR in the same cycle
        alu_en = 1'b1; alu_op = 5'd0; alu_a = 32'd10; alu_b = 32'd20;
        csr_acc(3'b001, 12'h343, 32'h0000_00AB);
        alu_en = 1'b0;
        check("dual alu", alu_out, 32'd30);
        csr_acc(3'b010, 12'h343, 32'h0);
        check("dual mtval", csr_rdata, 32'h0000_00AB);

        // Illegal ALU op is sticky
        alu_vec("ALU op20", 5'd20, 32'd1, 32'd1, 32'd0);
        check("alu_fault set", {31'b0, alu_fault}, 32'h1);
        check("fault set", {31'b0, fault}, 32'h1);
        alu_vec("ADD after fault", 5'd0, 32'd2, 32'd3, 32'd5);
        check("alu_fault sticky", {31'b0, alu_fault}, 32'h1);
        check("csr_fault indep", {31'b0, csr_fault}, 32'h0);

        // CSR faults
        csr_acc(3'b001, 12'h301, 32'h1);
        check("csrrw misa fault", {31'b0, csr_fault}, 32'h1);
        check("csrrw misa rdata", csr_rdata, 32'h0);
        csr_acc(3'b010, 12'h301, 32'h0);
        check("misa after fault", csr_rdata, MISA);
        check("csr_fault sticky", {31'b0, csr_fault}, 32'h1);

        // Asynchronous reset mid-operation
        reset = 1'b0;
        #1;
        check("async next_pc", next_pc, 32'h0);
        check("async alu_out", alu_out, 32'h0);
        check("async csr_rdata", csr_rdata, 32'h0);
        check("async fault", {29'b0, alu_fault, csr_fault, fault}, 32'h0);
        step();
        reset = 1'b1;
        csr_acc(3'b010, 12'h340, 32'h0);
        check("mscratch cleared", csr_rdata, 32'h0);
        csr_acc(3'b010, 12'h7FF, 32'h0);
        check("addr 7FF fault", {31'b0, csr_fault}, 32'h1);
        check("addr 7FF fault out", {31'b0, fault}, 32'h1);
        check("addr 7FF alu_fault", {31'b0, alu_fault}, 32'h0);

        do_reset();
        csr_acc(3'b000, 12'h340, 32'h5);
        check("op00 fault", {31'b0, csr_fault}, 32'h1);
        csr_acc(3'b001, 12'h340, 32'h0);
        check("op00 no write", csr_rdata, 32'h0);

        do_reset();
        csr_acc(3'b011, 12'hF14, 32'h1);
        check("clr mhartid nz fault", {31'b0, csr_fault}, 32'h1);

`ifdef EXEC_UNIT_MCYCLE_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (10) step();
        csr_acc(3'b010, 12'hB00, 32'h0);
        check("mcycle 10", csr_rdata, 32'd10);
        check("mcycle no fault", {31'b0, csr_fault}, 32'h0);
`else
        do_reset();
        csr_acc(3'b010, 12'hB00, 32'h0);
        check("mcycle absent fault", {31'b0, csr_fault}, 32'h1);
        check("mcycle absent rdata", csr_rdata, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter MISA_VALUE, default 32'h4000_0100 (RV32I), value returned by misa.
REQ-002 Parameter HART_ID, default 32'h0, value returned by mhartid.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 adder_en  in  1  enables registered PC adders this cycle.
REQ-006 pc  in  32  current program counter.
REQ-007 imm  in  32  decoded immediate (branch/jump offset).
REQ-008 next_pc  out  32  registered pc+4.
REQ-009 offset_pc  out  32  registered pc+imm.
REQ-010 alu_en  in  1  enables ALU operation this cycle.
REQ-011 alu_op  in  5  ALU operation code.
REQ-012 alu_a, alu_b  in  32 each  ALU operands.
REQ-013 alu_out  out  32  registered ALU result.
REQ-014 csr_en  in  1  enables CSR access this cycle.
REQ-015 csr_op  in  3  RISC-V funct3 of CSR instruction.
REQ-016 csr_addr  in  12  CSR address.
REQ-017 csr_wdata  in  32  write/set/clear operand (rs1 value or zero-extended uimm, muxed upstream).
REQ-018 csr_rdata  out  32  registered old CSR value.
REQ-019 alu_fault, csr_fault  out  1 each  sticky fault flags.
REQ-020 fault  out  1  alu_fault OR csr_fault.

Function
REQ-021 On a clk edge with adder_en=1: next_pc<=pc+4, offset_pc<=pc+imm, modulo 2^32 (carry dropped); otherwise both hold.
REQ-022 On a clk edge with alu_en=1, alu_out<=f(alu_op,a,b); otherwise hold; one-cycle latency.
REQ-023 alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; shifts use b[4:0]; SLT/SLTU yield 0/1.
REQ-024 alu_op 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU: alu_out = {31'b0, condition}; bit0 drives branch selection.
REQ-025 alu_op 16..31 with alu_en=1: alu_out<=0, alu_fault<=1.
REQ-026 CSR access with csr_en=1: csr_rdata<=old value; write value per csr_op[1:0]: 01 W (wdata), 10 S (old|wdata), 11 C (old&~wdata); new value visible next cycle.
REQ-027 csr_op[1:0]=00, unknown address, or op 01 (W) to a read-only CSR: csr_fault<=1, no state change, csr_rdata<=0.
REQ-028 S/C to read-only CSR with wdata=0 is legal (read only); nonzero wdata faults.
REQ-029 CSRs: mstatus 0x300 (RW, bits 3 and 7 only, others read 0), misa 0x301 (RO), mtvec 0x305 (RW, bits[1:0] read 0), mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mtval 0x343 (RW), mhartid 0xF14 (RO).
REQ-030 alu_en and csr_en in the same cycle operate independently; adder_en likewise.
REQ-031 Fault flags are sticky until reset; later legal operations do not clear them.

Reset
REQ-032 reset low asynchronously clears next_pc, offset_pc, alu_out, csr_rdata, all RW CSRs, mcycle, and both fault flags to 0.
REQ-033 Enables are ignored while reset is low; operation resumes on the first edge after deassertion.

Configuration
REQ-034 Macro EXEC_UNIT_MCYCLE_EN: when defined, 64-bit mcycle counter increments every clock; mcycle 0xB00 (low) and mcycleh 0xB80 (high) are RW; a write in the same cycle wins over the increment.
REQ-035 Without EXEC_UNIT_MCYCLE_EN, no counter exists and addresses 0xB00/0xB80 fault per REQ-027.

Structure
REQ-036 Package exec_unit_pkg holds ALU op enum, CSR op constants and CSR address localparams.
REQ-037 CSR storage and access logic live in sub-module exec_csr_file; ALU and adders stay in exec_unit.

Verification
REQ-038 pc=0x1000, imm=0xFFFF_FFF0, adder_en=1 -> next_pc=0x1004, offset_pc=0x0FF0 next cycle; pc=0xFFFF_FFFC -> next_pc=0.
REQ-039 ALU SRA a=0x8000_0000 b=4 -> 0xF800_0000; SLTU a=1 b=0xFFFF_FFFF -> 1; LT a=-1 b=0 -> alu_out=1.
REQ-040 alu_op=20 -> alu_fault=1, fault=1; then ADD 2+3 -> alu_out=5, alu_fault stays 1.
REQ-041 CSRRW mscratch 0xDEAD_BEEF, then CSRRS with 0x1 -> csr_rdata=0xDEAD_BEEF, next read 0xDEAD_BEEF; CSRRC 0xF -> mscratch=0xDEAD_BEE0.
REQ-042 CSRRW misa -> csr_fault=1; CSRRS misa wdata=0 -> csr_rdata=MISA_VALUE, no fault; address 0x7FF -> fault.
REQ-043 Reset low mid-operation -> all outputs 0 immediately; with EXEC_UNIT_MCYCLE_EN, mcycle read 10 cycles after reset release = 10 (counter starts at 0 on the first edge after release, REQ-034).
